// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit owning the architectural HI/LO registers.
// Ports: clk/rst (async active-high), Req cancels the E-stage op, mdu_op/E_rs/E_rt are the
//        decoded op and operands; start/busy feed the hazard unit; HI/LO/mdu_rd are the results.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Req,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] mdu_rd
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [7:0] MULT_N = 8'(MULT_CYCLES);
  localparam logic [7:0] DIV_N  = 8'(DIV_CYCLES);

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] temp_hi_q, temp_hi_d, temp_lo_q, temp_lo_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;

  logic        is_mul, is_div, sgn, idle_ok;
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, uq, ur, q, r;

  assign is_mul  = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
  assign is_div  = (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
  assign idle_ok = !busy_q && !Req;
  assign start   = (is_mul || is_div) && idle_ok;

  // Datapath: the signed forms are built from the unsigned core so that the
  // 0x80000000 / -1 overflow case naturally wraps to 0x80000000 rem 0.
  always_comb begin
    sgn   = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
    prod  = {{32{sgn & E_rs[31]}}, E_rs} * {{32{sgn & E_rt[31]}}, E_rt};
    a_mag = (sgn && E_rs[31]) ? -E_rs : E_rs;
    b_mag = (sgn && E_rt[31]) ? -E_rt : E_rt;
    uq    = '0;
    ur    = '0;
    if (b_mag != 32'd0) begin
      uq = a_mag / b_mag;
      ur = a_mag % b_mag;
    end
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    q = (sgn && (E_rs[31] ^ E_rt[31])) ? -uq : uq;
    r = (sgn && E_rs[31]) ? -ur : ur;
  end

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    if (busy_q) begin
      // Countdown is never cancelled by Req: the in-flight op is older than the fault.
      if (cnt_q > 8'd1) begin
        cnt_d = cnt_q - 8'd1;
      end else begin
        hi_d   = temp_hi_q;
        lo_d   = temp_lo_q;
        busy_d = 1'b0;
        cnt_d  = 8'd0;
      end
    end else if (start) begin
      busy_d = 1'b1;
      if (is_mul) begin
        temp_hi_d = prod[63:32];
        temp_lo_d = prod[31:0];
        cnt_d     = MULT_N;
      end else begin
        cnt_d = DIV_N;
        // A zero divisor commits the current HI/LO, leaving them unchanged.
        // MT writes are blocked while busy, so these values stay current.
        if (E_rt == 32'd0) begin
          temp_hi_d = hi_q;
          temp_lo_d = lo_q;
        end else begin
          temp_hi_d = r;
          temp_lo_d = q;
        end
      end
    end else if (idle_ok && (mdu_op == OP_MTHI)) begin
      hi_d = E_rs;
    end else if (idle_ok && (mdu_op == OP_MTLO)) begin
      lo_d = E_rs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q      <= '0;
      lo_q      <= '0;
      temp_hi_q <= '0;
      temp_lo_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign mdu_rd = (mdu_op == OP_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed and randomized checks of e_mdu against a behavioural model.
// The model tracks HI/LO and a pending result with an absolute commit edge number;
// a negedge process compares every output each cycle, plus literal expectations.
module tb_e_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Req = 1'b0;
  logic [3:0]  mdu_op = 4'd0;
  logic [31:0] E_rs = '0;
  logic [31:0] E_rt = '0;
  logic        start, busy;
  logic [31:0] HI, LO, mdu_rd;

  int n_vec = 0;
  int n_err = 0;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .Req(Req), .mdu_op(mdu_op), .E_rs(E_rs), .E_rt(E_rt),
    .start(start), .busy(busy), .HI(HI), .LO(LO), .mdu_rd(mdu_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic written with 64-bit integer math.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    p  = '0;
    case (op)
      4'd1: p = 64'(sa * sb);
      4'd2: p = {32'd0, a} * {32'd0, b};
      4'd3: if (b != 0) begin
        sq = sa / sb;
        sr = sa % sb;
        p  = {sr[31:0], sq[31:0]};
      end
      4'd4: if (b != 0) p = {a % b, a / b};
      default: p = '0;
    endcase
    return p;
  endfunction

  // Behavioural model: state after each edge.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        pend = 1'b0, p_div0 = 1'b0;
  int          e_no = 0, commit_e = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi <= '0;
      m_lo <= '0;
      pend <= 1'b0;
    end else begin
      e_no <= e_no + 1;
      if (pend) begin
        if (e_no == commit_e) begin
          pend <= 1'b0;
          if (!p_div0) begin
            m_hi <= p_hi;
            m_lo <= p_lo;
          end
        end
      end else if (!Req) begin
        if (mdu_op >= 4'd1 && mdu_op <= 4'd4) begin
          pend     <= 1'b1;
          commit_e <= e_no + ((mdu_op <= 4'd2) ? MC : DC);
          {p_hi, p_lo} <= ref_result(mdu_op, E_rs, E_rt);
          p_div0   <= (mdu_op >= 4'd3) && (E_rt == 32'd0);
        end else if (mdu_op == 4'd7) begin
          m_hi <= E_rs;
        end else if (mdu_op == 4'd8) begin
          m_lo <= E_rs;
        end
      end
    end
  end

  // Compare process: inputs are stable from posedge+2 until the next posedge.
  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, pend});
    chk("HI", HI, m_hi);
    chk("LO", LO, m_lo);
    chk("start", {31'd0, start},
        {31'd0, (mdu_op >= 4'd1 && mdu_op <= 4'd4 && !pend && !Req)});
    chk("mdu_rd", mdu_rd, (mdu_op == 4'd5) ? m_hi : m_lo);
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rq);
    mdu_op = op;
    E_rs   = a;
    E_rt   = b;
    Req    = rq;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'(int'($urandom_range(0, 20)) - 10);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #22;
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #2;

    // MULT -2 * 3
    drive(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult busy at issue", {31'd0, busy}, 32'd1);
    idle(4);
    chk("mult busy edge4", {31'd0, busy}, 32'd1);
    chk("mult LO before commit", LO, 32'd0);
    drive(4'd6, 32'd0, 32'd0, 1'b0);
    chk("mult HI", HI, 32'hFFFF_FFFF);
    chk("mult LO", LO, 32'hFFFF_FFFA);
    chk("mult busy after", {31'd0, busy}, 32'd0);
    chk("mult MFLO", mdu_rd, 32'hFFFF_FFFA);

    // DIVU 100 / 7
    drive(4'd4, 32'd100, 32'd7, 1'b0);
    idle(9);
    chk("divu LO before commit", LO, 32'hFFFF_FFFA);
    idle(1);
    chk("divu LO", LO, 32'd14);
    chk("divu HI", HI, 32'd2);

    // DIV -7 / 2
    drive(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(10);
    chk("div -7/2 LO", LO, 32'hFFFF_FFFD);
    chk("div -7/2 HI", HI, 32'hFFFF_FFFF);

    // DIV overflow case
    drive(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(10);
    chk("div ovf LO", LO, 32'h8000_0000);
    chk("div ovf HI", HI, 32'd0);

    // DIV by zero keeps preloaded HI/LO
    drive(4'd7, 32'h11, 32'd0, 1'b0);
    drive(4'd8, 32'h22, 32'd0, 1'b0);
    drive(4'd3, 32'd5, 32'd0, 1'b0);
    idle(9);
    chk("div0 busy edge9", {31'd0, busy}, 32'd1);
    idle(1);
    chk("div0 busy after", {31'd0, busy}, 32'd0);
    chk("div0 HI", HI, 32'h11);
    chk("div0 LO", LO, 32'h22);

    // Req blocks issue
    mdu_op = 4'd1; E_rs = 32'd5; E_rt = 32'd5; Req = 1'b1;
    #1;
    chk("req start", {31'd0, start}, 32'd0);
    @(posedge clk);
    #2;
    chk("req busy", {31'd0, busy}, 32'd0);
    chk("req LO", LO, 32'h22);

    // Req during in-flight MULT does not abort it
    drive(4'd1, 32'd5, 32'd5, 1'b0);
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    drive(4'd0, 32'd0, 32'd0, 1'b1);
    idle(2);
    chk("req inflight LO pre", LO, 32'h22);
    idle(1);
    chk("req inflight LO", LO, 32'd25);

    // MTHI, then ops while busy are ignored
    drive(4'd7, 32'hDEAD_BEEF, 32'd0, 1'b0);
    chk("mthi HI", HI, 32'hDEAD_BEEF);
    drive(4'd1, 32'd2, 32'd3, 1'b0);
    drive(4'd8, 32'd1, 32'd0, 1'b0);
    drive(4'd1, 32'd7, 32'd7, 1'b0);
    idle(2);
    chk("busy-ignored LO pre", LO, 32'd25);
    idle(1);
    chk("busy-ignored LO", LO, 32'd6);
    idle(1);
    chk("no second busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-DIV
    drive(4'd3, 32'd100, 32'd3, 1'b0);
    idle(2);
    #1 rst = 1'b1;
    #1;
    chk("async rst HI", HI, 32'd0);
    chk("async rst LO", LO, 32'd0);
    chk("async rst busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    idle(12);
    chk("post rst LO", LO, 32'd0);
    chk("post rst busy", {31'd0, busy}, 32'd0);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op;
      if ($urandom_range(0, 5) == 0) op = 4'($urandom_range(9, 15));
      else op = 4'($urandom_range(0, 8));
      drive(op, rand_val(), rand_val(), ($urandom_range(0, 7) == 0));
    end
    idle(DC + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit. Sits directly downstream of the D/E pipeline register.
- Consumes the E-stage operands (E_rs, E_rt) and a decoded op from the E-stage instruction.
- Owns the architectural HI/LO registers and models the multi-cycle MULT/DIV latency.
- Drives busy/start so the hazard unit can stall D on any HI/LO-touching instruction.

Parameters:
MULT_CYCLES, 5, cycles from MULT/MULTU issue edge to HI/LO commit edge (legal 1..255)
DIV_CYCLES, 10, cycles from DIV/DIVU issue edge to HI/LO commit edge (legal 1..255)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
Req  input  1  exception/interrupt request; cancels the E-stage instruction this cycle
mdu_op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, others are treated as NONE
E_rs  input  32  operand A (dividend/multiplicand, MTHI/MTLO source)
E_rt  input  32  operand B (divisor/multiplier)
start  output  1  combinational: op is 1..4 and busy=0 and Req=0
busy  output  1  registered: operation in flight
HI  output  32  architectural HI
LO  output  32  architectural LO
mdu_rd  output  32  combinational: HI if op=MFHI, else LO

Behaviour:
- Reset (async, immediate): HI=0, LO=0, busy=0, internal counter=0, temp results=0.
  - Reset mid-operation abandons the operation. No commit occurs.
- Issue: on an edge with start=1:
  - compute the full result from E_rs/E_rt into temp_hi/temp_lo;
  - load cnt=N (MULT_CYCLES or DIV_CYCLES);
  - set busy=1.
- Countdown: each edge with busy=1:
  - if cnt>1: cnt<=cnt-1;
  - if cnt==1: HI<=temp_hi, LO<=temp_lo, busy<=0, cnt<=0.
- Timing: busy is high for exactly N cycles after the issue edge. HI/LO change at issue edge + N. The next op is accepted in the first cycle where busy=0.
- Arithmetic:
  - MULT: signed 32x32 -> 64 bits. MULTU: unsigned. HI = product[63:32], LO = product[31:0].
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Signed divide truncates toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
  - Divisor 0: the op still issues and holds busy for DIV_CYCLES, but HI/LO stay unchanged at commit.
- MTHI/MTLO: when busy=0 and Req=0, write E_rs into HI/LO at the edge. Otherwise ignored.
- Any op other than NONE while busy=1 is ignored. The hazard unit stalls on (busy|start) for ops 1..8, so this case never occurs legally; it must still be harmless.
- Req=1:
  - blocks start and MT writes in that cycle;
  - does NOT abort an operation already in flight, because that instruction precedes the faulting one;
  - Req in the same cycle as a commit: the commit still happens.
- MFHI/MFLO: mdu_rd reflects the current HI/LO registers. There is no bypass of an in-flight temp result; the stall guarantees correctness.

Test Plan:
- MULT E_rs=0xFFFFFFFE (-2), E_rt=3 at edge 0: busy=1 for edges 0..4. At edge 5, HI=0xFFFFFFFF and LO=0xFFFFFFFA; busy=0 and mdu_rd(MFLO)=0xFFFFFFFA.
- DIVU 100/7: HI/LO unchanged until edge 10, then LO=14, HI=2. Signed DIV -7/2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. Signed DIV 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- DIV by 0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO: busy high for 10 cycles, then HI=0x11 and LO=0x22 unchanged.
- Req=1 together with MULT 5*5: start=0, busy stays 0, HI/LO unchanged. Req=1 at cycle 2 of an in-flight MULT 5*5: LO=25 still commits at edge 5.
- MTHI 0xDEADBEEF with Req=0 writes HI. MTLO 0x1 while busy is ignored. A MULT issued while busy is ignored: the original result commits and no second busy window follows.
- Assert rst asynchronously mid-DIV (between clock edges): HI=LO=0 and busy=0 immediately, and no commit follows after release.
